// File: rtl/program_counter.sv
// Program counter: holds the current instruction address; each rising clock
// edge it resets, stalls, loads a jump target, increments, or holds.
// `wrapped` pulses for one cycle after an increment from all-ones to zero.
module program_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             wrapped
);

  localparam int unsigned SUM_W = WIDTH + 1;

  logic [SUM_W-1:0] sum;
  logic [WIDTH-1:0] inc_sel;
  logic [WIDTH-1:0] load_sel;
  logic [WIDTH-1:0] next_out;
  logic             carry;
  logic             next_wrapped;

  // Incrementer: the carry out of the MSB is exactly the wrap condition
  always_comb begin
    sum   = {1'b0, out} + SUM_W'(1);
    carry = sum[WIDTH];
  end

  // Mux chain: inc/hold, then load, then stall hold, then synchronous reset
  always_comb begin
    inc_sel      = out;
    load_sel     = out;
    next_out     = out;
    next_wrapped = 1'b0;

    inc_sel  = inc  ? sum[WIDTH-1:0] : out;
    load_sel = load ? in             : inc_sel;
    next_out = stall ? out           : load_sel;

    // Only a real increment (not blocked by stall or overridden by load) can wrap
    next_wrapped = ~stall & ~load & inc & carry;

    if (reset) begin
      next_out     = '0;
      next_wrapped = 1'b0;
    end
  end

  // Address and wrap-flag registers
  always_ff @(posedge clock) begin
    out     <= next_out;
    wrapped <= next_wrapped;
  end

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: table-driven vectors on a 16-bit
// instance plus hand-written sequences on a 4-bit instance.
module tb_program_counter;

  logic        clock;
  logic        reset, stall, load, inc;
  logic [15:0] in;
  logic [15:0] out;
  logic        wrapped;

  logic        reset4, stall4, load4, inc4;
  logic [3:0]  in4;
  logic [3:0]  out4;
  logic        wrapped4;

  int total;
  int bad;

  program_counter #(.WIDTH(16)) dut (
    .clock(clock), .reset(reset), .stall(stall), .load(load), .inc(inc),
    .in(in), .out(out), .wrapped(wrapped)
  );

  program_counter #(.WIDTH(4)) dut4 (
    .clock(clock), .reset(reset4), .stall(stall4), .load(load4), .inc(inc4),
    .in(in4), .out(out4), .wrapped(wrapped4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        reset;
    logic        stall;
    logic        load;
    logic        inc;
    logic [15:0] in;
    logic [15:0] exp_out;
    logic        exp_wrapped;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic r, input logic s, input logic l,
                     input logic i, input logic [15:0] d, input logic [15:0] eo,
                     input logic ew);
    vec_t v;
    v.name = n; v.reset = r; v.stall = s; v.load = l; v.inc = i; v.in = d;
    v.exp_out = eo; v.exp_wrapped = ew;
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // One clock on the 4-bit instance: drive at negedge, sample 1 after posedge
  task automatic step4(input logic r, input logic i, input string n,
                       input logic [3:0] eo, input logic ew);
    @(negedge clock);
    reset4 = r; stall4 = 1'b0; load4 = 1'b0; inc4 = i; in4 = 4'h0;
    @(posedge clock);
    #1;
    check({n, ".out"}, 32'(out4), 32'(eo));
    check({n, ".wrapped"}, 32'(wrapped4), 32'(ew));
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 0; stall = 0; load = 0; inc = 0; in = '0;
    reset4 = 0; stall4 = 0; load4 = 0; inc4 = 0; in4 = '0;

    //    name          rst stl ld inc in        out       wr
    add("reset_wins",   1, 0, 1, 1, 16'h1234, 16'h0000, 0);
    add("inc1",         0, 0, 0, 1, 16'h0000, 16'h0001, 0);
    add("inc2",         0, 0, 0, 1, 16'h0000, 16'h0002, 0);
    add("inc3",         0, 0, 0, 1, 16'h0000, 16'h0003, 0);
    add("inc4",         0, 0, 0, 1, 16'h0000, 16'h0004, 0);
    add("inc5",         0, 0, 0, 1, 16'h0000, 16'h0005, 0);
    add("idle1",        0, 0, 0, 0, 16'hABCD, 16'h0005, 0);
    add("idle2",        0, 0, 0, 0, 16'h0000, 16'h0005, 0);
    add("idle3",        0, 0, 0, 0, 16'h0000, 16'h0005, 0);
    add("load_fffe",    0, 0, 1, 0, 16'hFFFE, 16'hFFFE, 0);
    add("to_ffff",      0, 0, 0, 1, 16'h0000, 16'hFFFF, 0);
    add("wrap",         0, 0, 0, 1, 16'h0000, 16'h0000, 1);
    add("after_wrap",   0, 0, 0, 1, 16'h0000, 16'h0001, 0);
    add("load_0010",    0, 0, 1, 0, 16'h0010, 16'h0010, 0);
    add("load_over_inc",0, 0, 1, 1, 16'h0200, 16'h0200, 0);
    add("load_ffff",    0, 0, 1, 0, 16'hFFFF, 16'hFFFF, 0);
    add("load0_nowrap", 0, 0, 1, 0, 16'h0000, 16'h0000, 0);
    add("load_0042",    0, 0, 1, 0, 16'h0042, 16'h0042, 0);
    add("stall1",       0, 1, 1, 1, 16'h0999, 16'h0042, 0);
    add("stall2",       0, 1, 1, 1, 16'h0999, 16'h0042, 0);
    add("stall3",       0, 1, 1, 1, 16'h0999, 16'h0042, 0);
    add("stall4",       0, 1, 1, 1, 16'h0999, 16'h0042, 0);
    add("resume",       0, 0, 0, 1, 16'h0000, 16'h0043, 0);
    add("load_ffff_b",  0, 0, 1, 0, 16'hFFFF, 16'hFFFF, 0);
    add("wrap_b",       0, 0, 0, 1, 16'h0000, 16'h0000, 1);
    add("stall_clr_wr", 0, 1, 0, 1, 16'h0000, 16'h0000, 0);
    add("stall_inc",    0, 0, 0, 1, 16'h0000, 16'h0001, 0);
    add("inc_ffff_stl", 0, 0, 1, 0, 16'hFFFF, 16'hFFFF, 0);
    add("stall_at_max", 0, 1, 0, 1, 16'h0000, 16'hFFFF, 0);
    add("reset_stall",  1, 1, 0, 1, 16'h0000, 16'h0000, 0);
    add("post_reset",   0, 0, 0, 1, 16'h0000, 16'h0001, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clock);
      reset = vecs[k].reset; stall = vecs[k].stall; load = vecs[k].load;
      inc = vecs[k].inc; in = vecs[k].in;
      @(posedge clock);
      #1;
      check({vecs[k].name, ".out"}, 32'(out), 32'(vecs[k].exp_out));
      check({vecs[k].name, ".wrapped"}, 32'(wrapped), 32'(vecs[k].exp_wrapped));
    end
    @(negedge clock);
    reset = 0; stall = 0; load = 0; inc = 0;

    // 4-bit: full lap of 16 increments, wrap pulse on the last one only
    step4(1'b1, 1'b1, "w4_reset", 4'h0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      step4(1'b0, 1'b1, $sformatf("w4_inc%0d", i), 4'(i), (i == 16));
    end
    step4(1'b0, 1'b1, "w4_after_wrap", 4'h1, 1'b0);
    for (int i = 2; i <= 7; i++) begin
      step4(1'b0, 1'b1, $sformatf("w4_count%0d", i), 4'(i), 1'b0);
    end
    // Mid-count reset with inc still held, then counting restarts without skipping
    step4(1'b1, 1'b1, "w4_mid_reset", 4'h0, 1'b0);
    step4(1'b0, 1'b1, "w4_restart1", 4'h1, 1'b0);
    step4(1'b0, 1'b1, "w4_restart2", 4'h2, 1'b0);
    step4(1'b0, 1'b0, "w4_hold", 4'h2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
